// File: rtl/mealy.sv
// mealy: Mealy pulse-count detector that flags every N_PULSES-th event after arming.
//   clk   - system clock, state updates on the rising edge
//   reset - asynchronous active-low reset (IDLE, count cleared, out forced low)
//   a     - command/event code: 00 idle level, 01 event high, 10 arm, 11 abort
//   out   - combinational detect, high in the cycle the N-th rising event is sampled
module mealy #(
    parameter int N_PULSES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] a,
    output logic       out
);
    localparam int CW = $clog2(N_PULSES + 1);
    localparam logic [CW-1:0] LAST = CW'(N_PULSES - 1);
    localparam logic [1:0] A_LOW   = 2'b00;
    localparam logic [1:0] A_EVT   = 2'b01;
    localparam logic [1:0] A_ARM   = 2'b10;
    localparam logic [1:0] A_ABORT = 2'b11;

    typedef enum logic [1:0] {IDLE, ARMED_LOW, ARMED_HIGH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit;

    // A rising event only counts from ARMED_LOW; ARMED_HIGH absorbs a held level.
    assign hit = (state_q == ARMED_LOW) && (a == A_EVT) && (cnt_q == LAST);
    assign out = hit && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (a == A_ARM) begin
                    state_d = ARMED_LOW;
                    cnt_d   = '0;
                end
            end
            ARMED_LOW: begin
                case (a)
                    A_EVT: begin
                        state_d = ARMED_HIGH;
                        // wrap to 0 on detection so the next group starts fresh
                        cnt_d   = hit ? '0 : cnt_q + CW'(1);
                    end
                    A_ARM:   cnt_d = '0;
                    A_ABORT: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                    default: ;
                endcase
            end
            ARMED_HIGH: begin
                case (a)
                    A_LOW: state_d = ARMED_LOW;
                    A_ARM: begin
                        state_d = ARMED_LOW;
                        cnt_d   = '0;
                    end
                    A_ABORT: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                    default: ;
                endcase
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_mealy.sv
// tb_mealy: directed self-checking bench for mealy (N_PULSES=3 and N_PULSES=1 instances).
module tb_mealy;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] a = 2'b00;
    logic       out;
    logic       out1;
    int         checks = 0;
    int         errors = 0;

    mealy #(.N_PULSES(3)) dut  (.clk(clk), .reset(reset), .a(a), .out(out));
    mealy #(.N_PULSES(1)) dut1 (.clk(clk), .reset(reset), .a(a), .out(out1));

    always #5 clk = ~clk;

    // apply a code mid-cycle, settle, leave the rising edge ahead
    task automatic drive(input logic [1:0] v);
        @(negedge clk);
        a = v;
        #1;
    endtask

    task automatic test_reset;
        a = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out !== 1'b0) begin
                errors++;
                $display("FAIL reset_out cyc%0d got %b want 0", i, out);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'b01);
            checks++;
            if (out !== 1'b0) begin
                errors++;
                $display("FAIL idle_evt cyc%0d got %b want 0", i, out);
            end
        end
        drive(2'b11);
        drive(2'b00);
    endtask

    task automatic test_count(input string tag);
        logic [1:0] s[6] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        logic       e[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(s[i]);
            checks++;
            if (out !== e[i]) begin
                errors++;
                $display("FAIL %s step%0d got %b want %b", tag, i, out, e[i]);
            end
        end
    endtask

    task automatic test_held;
        logic [1:0] s[10] = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01};
        logic       e[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            drive(s[i]);
            checks++;
            if (out !== e[i]) begin
                errors++;
                $display("FAIL held step%0d got %b want %b", i, out, e[i]);
            end
        end
        drive(2'b00);
    endtask

    task automatic test_rearm;
        // rearm from ARMED_LOW with cnt=2, then prove cnt=1 after one pulse
        logic [1:0] s[11] = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
        logic       e[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        // rearm from ARMED_HIGH: held level is not counted
        logic [1:0] h[11] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        logic       g[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 11; i++) begin
            drive(s[i]);
            checks++;
            if (out !== e[i]) begin
                errors++;
                $display("FAIL rearm_low step%0d got %b want %b", i, out, e[i]);
            end
        end
        for (int i = 0; i < 11; i++) begin
            drive(h[i]);
            checks++;
            if (out !== g[i]) begin
                errors++;
                $display("FAIL rearm_high step%0d got %b want %b", i, out, g[i]);
            end
        end
    endtask

    task automatic test_abort;
        logic [1:0] s[10] = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
        for (int i = 0; i < 10; i++) begin
            drive(s[i]);
            checks++;
            if (out !== 1'b0) begin
                errors++;
                $display("FAIL abort step%0d got %b want 0", i, out);
            end
        end
        drive(2'b00);
    endtask

    task automatic test_async_reset;
        logic [1:0] s[5] = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b00};
        logic [1:0] p[5] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
        for (int i = 0; i < 5; i++) drive(s[i]);
        drive(2'b01);
        checks++;
        if (out !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_hit got %b want 1", out);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL async_drop got %b want 0", out);
        end
        @(negedge clk);
        a = 2'b00;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(p[i]);
            checks++;
            if (out !== 1'b0) begin
                errors++;
                $display("FAIL post_reset step%0d got %b want 0", i, out);
            end
        end
        drive(2'b00);
        drive(2'b10);
        for (int i = 0; i < 5; i++) begin
            drive(p[i]);
            checks++;
            if (out !== (i == 4)) begin
                errors++;
                $display("FAIL rearmed step%0d got %b want %b", i, out, i == 4);
            end
        end
        drive(2'b00);
    endtask

    task automatic test_n1;
        logic [1:0] s[7] = '{2'b11, 2'b10, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
        logic       e[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive(s[i]);
            checks++;
            if (out1 !== e[i]) begin
                errors++;
                $display("FAIL n1 step%0d got %b want %b", i, out1, e[i]);
            end
        end
    endtask

    initial begin
        test_reset;
        drive(2'b10);
        test_count("group1");
        test_count("group2");
        test_held;
        test_rearm;
        test_abort;
        test_async_reset;
        test_n1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mealy.md
Name: mealy

Overview:
- Mealy-type pulse-count detector driven by a 2-bit command/event input `a`.
- `a[1]` arms or re-arms the detector; `a[0]` carries event pulses.
- `out` is asserted combinationally during the cycle in which the N-th event pulse after arming is sampled.
- Used as a small control FSM that flags every N-th event on a sampled input line.

Parameters:
- N_PULSES, default 3: number of event pulses (rising levels of `a[0]`) counted per detection. Legal range 1..255.

Ports:
- clk  input  1: system clock. All state updates on the rising edge.
- reset  input  1: asynchronous, active-low reset. Low forces the FSM to IDLE and the count to 0 immediately.
- a  input  2: command/event code. 00 = idle level, 01 = event high, 10 = arm, 11 = abort.
- out  output  1: Mealy detect output. Combinational function of current state, count and `a`.

Behaviour:
- Registers:
  - state: IDLE, ARMED_LOW, ARMED_HIGH.
  - cnt: width clog2(N_PULSES+1), unsigned.
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0.
  - out=0 regardless of `a` while reset is low.
  - Release is sampled at the next rising clk.
- IDLE:
  - a=10: go to ARMED_LOW, cnt=0.
  - All other codes: stay in IDLE.
  - out=0.
- ARMED_LOW (armed, waiting for an event):
  - a=00: stay.
  - a=01, cnt<N_PULSES-1: go to ARMED_HIGH, cnt+1, out=0.
  - a=01, cnt==N_PULSES-1: out=1 combinationally in this same cycle. Next state ARMED_HIGH, cnt=0, so the detector keeps counting the following group.
  - a=10: re-arm. Stay in ARMED_LOW, cnt=0.
  - a=11: abort. Go to IDLE, cnt=0.
- ARMED_HIGH (event level still high):
  - a=01: stay. No count, out=0. A held-high level counts once.
  - a=00: go to ARMED_LOW, cnt unchanged.
  - a=10: re-arm. Go to ARMED_LOW, cnt=0.
  - a=11: go to IDLE, cnt=0.
- Output equation: out = (state==ARMED_LOW) && (a==01) && (cnt==N_PULSES-1) && reset.
  - Zero latency from `a`. Not registered.
  - No glitch requirement beyond standard synchronous sampling.
- Input sampling:
  - `a` is assumed synchronous to clk.
  - Only its value at the rising edge affects state.
  - out follows `a` within the cycle.
- Boundary conditions:
  - N_PULSES=1: every 00→01 transition while armed asserts out.
  - cnt never exceeds N_PULSES-1, so there is no wrap-around overflow.
  - A 01 seen in IDLE is ignored; the detector must be armed first.
  - Reset mid-sequence discards the partial count. After release the FSM requires a new arm (10).
  - Arm during ARMED_HIGH clears the count. The current high level is not counted until `a` returns to 00 and rises again.

Test Plan:
- Reset low with a=01 held → out=0 and state IDLE. Release reset, a=01 for 3 cycles → out stays 0 (not armed).
- N_PULSES=3, a=10 for 1 cycle, then 01,00,01,00,01,00 (one cycle each) → out=1 only during the third 01 cycle, 0 elsewhere.
- Continue the previous scenario with 01,00,01,00,01,00 → out=1 on the sixth pulse overall (third of the second group) only; cnt=0 afterwards.
- Arm, 01,00,01, then a=01 held 4 cycles → out=0 throughout (held level counts once), cnt=2. Then 00,01 → out=1.
- Arm, 01,00,01,00, then a=10, then 01,00 → out=0 (re-arm cleared the count), cnt=1.
- Arm, 01,00, assert reset low asynchronously mid-cycle → out drops to 0 immediately, state IDLE. Release, then 01,00,01,00,01 → out=0 (re-arm required).
